// File: rtl/tl_pkg.sv
// Shared types and light encodings for the two-road traffic-light controller.
package tl_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5
    } tl_state_t;

    // {R,Y,G} one-hot lamp drive
    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

endpackage

// File: rtl/tl_dwell_timer.sv
// Tick-driven dwell counter for the traffic-light FSM.
// Counts timebase ticks, clears on request, and holds at limit-1 so the
// resting main-road green can wait indefinitely without wrapping.
module tl_dwell_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             clr,
    input  logic [CNT_W:0]   limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   last_val;
    logic             at_last;

    // limit is one bit wider than the counter so a full 2**CNT_W dwell fits
    assign last_val = limit - {{CNT_W{1'b0}}, 1'b1};
    assign at_last  = ({1'b0, cnt_q} == last_val);
    assign done     = tick & at_last;

    // Next count: clear wins, otherwise advance on tick until the last value
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick && !at_last) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light Moore controller. Main road (NS) rests green; the
// side road (EW) is served only after a latched sensor request, with yellow
// and all-red clearance between greens. All dwells are counted in ticks.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   NS_GREEN  | main road green, waits for min green + request
//   NS_YELLOW | main road yellow
//   ALL_RED_A | clearance before side road green
//   EW_GREEN  | side road green, fixed dwell
//   EW_YELLOW | side road yellow
//   ALL_RED_B | clearance before main road green
module traffic_light_ctrl
    import tl_pkg::*;
#(
    parameter int GREEN_TICKS  = 4,
    parameter int YELLOW_TICKS = 2,
    parameter int RED_TICKS    = 1,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       sensor_ew,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [2:0] state_o,
    output logic       ew_req_o
);

    localparam logic [CNT_W:0] GREEN_LIM  = (CNT_W+1)'(GREEN_TICKS);
    localparam logic [CNT_W:0] YELLOW_LIM = (CNT_W+1)'(YELLOW_TICKS);
    localparam logic [CNT_W:0] RED_LIM    = (CNT_W+1)'(RED_TICKS);

    tl_state_t      state_q, state_d;
    logic           ew_req_q, ew_req_d;
    logic [2:0]     ns_light_q, ns_light_d;
    logic [2:0]     ew_light_q, ew_light_d;
    logic [CNT_W:0] dwell_limit;
    logic           dwell_done;
    logic           state_chg;

    // Dwell length for the state currently occupied
    always_comb begin
        case (state_q)
            NS_GREEN, EW_GREEN:    dwell_limit = GREEN_LIM;
            NS_YELLOW, EW_YELLOW:  dwell_limit = YELLOW_LIM;
            default:               dwell_limit = RED_LIM;
        endcase
    end

    tl_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .clr   (state_chg),
        .limit (dwell_limit),
        .done  (dwell_done)
    );

    // Next state, request latch and registered light decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            NS_GREEN:  if (dwell_done && (ew_req_q || sensor_ew)) state_d = NS_YELLOW;
            NS_YELLOW: if (dwell_done) state_d = ALL_RED_A;
            ALL_RED_A: if (dwell_done) state_d = EW_GREEN;
            EW_GREEN:  if (dwell_done) state_d = EW_YELLOW;
            EW_YELLOW: if (dwell_done) state_d = ALL_RED_B;
            ALL_RED_B: if (dwell_done) state_d = NS_GREEN;
            default:   state_d = NS_GREEN;
        endcase

        state_chg = (state_d != state_q);

        // the request being served is dropped as EW green starts; a sensor
        // hit on that same edge is considered already served
        if (state_chg && (state_d == EW_GREEN)) begin
            ew_req_d = 1'b0;
        end else begin
            ew_req_d = ew_req_q | sensor_ew;
        end

        // lights follow the state register exactly, decoded one edge early
        ns_light_d = LIGHT_R;
        ew_light_d = LIGHT_R;
        case (state_d)
            NS_GREEN:  ns_light_d = LIGHT_G;
            NS_YELLOW: ns_light_d = LIGHT_Y;
            EW_GREEN:  ew_light_d = LIGHT_G;
            EW_YELLOW: ew_light_d = LIGHT_Y;
            default: ;
        endcase
    end

    // State, request and light registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= NS_GREEN;
            ew_req_q   <= 1'b0;
            ns_light_q <= LIGHT_G;
            ew_light_q <= LIGHT_R;
        end else begin
            state_q    <= state_d;
            ew_req_q   <= ew_req_d;
            ns_light_q <= ns_light_d;
            ew_light_q <= ew_light_d;
        end
    end

    assign ns_light = ns_light_q;
    assign ew_light = ew_light_q;
    assign state_o  = state_q;
    assign ew_req_o = ew_req_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: vector table, periodic-tick sequences,
// async reset checks, and a held-tick run with lamp safety checks.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       sensor_ew = 1'b0;
    logic [2:0] ns_light, ew_light, state_o;
    logic       ew_req_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] st;
        logic       req;
        string      name;
    } exp_t;
    exp_t sb_q[$];

    typedef struct packed {
        logic       t;
        logic       s;
        logic [2:0] st;
        logic       req;
    } vec_t;
    vec_t vecs[24];

    logic [2:0] seq6[14];

    traffic_light_ctrl #(
        .GREEN_TICKS  (4),
        .YELLOW_TICKS (2),
        .RED_TICKS    (1),
        .CNT_W        (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .sensor_ew (sensor_ew),
        .ns_light  (ns_light),
        .ew_light  (ew_light),
        .state_o   (state_o),
        .ew_req_o  (ew_req_o)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ns_of(input logic [2:0] s);
        case (s)
            3'd0:    return 3'b001;
            3'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] ew_of(input logic [2:0] s);
        case (s)
            3'd3:    return 3'b001;
            3'd4:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // expected state after n ticks of a served request, starting from reset
    function automatic logic [2:0] state_after_ticks(input int n);
        int bounds[6] = '{4, 6, 7, 11, 13, 14};
        int k = 0;
        if (n >= 14) return 3'd0;
        for (int i = 0; i < 6; i++) if (n >= bounds[i]) k++;
        return 3'(k);
    endfunction

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // drive one cycle at negedge, expect the result after the next posedge
    task automatic step(input logic t, input logic s, input logic [2:0] exp_st,
                        input logic exp_req, input string name);
        exp_t e;
        tick = t;
        sensor_ew = s;
        e.st = exp_st;
        e.req = exp_req;
        e.name = name;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        check3({e.name, "/state"}, state_o, e.st);
        check3({e.name, "/ns"}, ns_light, ns_of(e.st));
        check3({e.name, "/ew"}, ew_light, ew_of(e.st));
        check3({e.name, "/req"}, {2'b00, ew_req_o}, {2'b00, e.req});
        checks++;
        if (!($onehot(ns_light) && $onehot(ew_light) &&
              (ns_light == 3'b100 || ew_light == 3'b100))) begin
            failures++;
            $display("FAIL %s/safety actual ns=%b ew=%b required one-hot with a red road",
                     e.name, ns_light, ew_light);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        tick = 1'b0;
        sensor_ew = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int ticks;
        logic t;

        // vectors from reset: {tick, sensor, state after edge, req after edge}
        vecs[0]  = {1'b0, 1'b0, 3'd0, 1'b0};
        vecs[1]  = {1'b1, 1'b0, 3'd0, 1'b0};
        vecs[2]  = {1'b1, 1'b0, 3'd0, 1'b0};
        vecs[3]  = {1'b1, 1'b0, 3'd0, 1'b0};
        vecs[4]  = {1'b1, 1'b0, 3'd0, 1'b0};
        vecs[5]  = {1'b1, 1'b0, 3'd0, 1'b0};
        vecs[6]  = {1'b0, 1'b1, 3'd0, 1'b1};
        vecs[7]  = {1'b0, 1'b0, 3'd0, 1'b1};
        vecs[8]  = {1'b1, 1'b0, 3'd1, 1'b1};
        vecs[9]  = {1'b0, 1'b0, 3'd1, 1'b1};
        vecs[10] = {1'b1, 1'b0, 3'd1, 1'b1};
        vecs[11] = {1'b1, 1'b0, 3'd2, 1'b1};
        vecs[12] = {1'b1, 1'b1, 3'd3, 1'b0};
        vecs[13] = {1'b1, 1'b0, 3'd3, 1'b0};
        vecs[14] = {1'b1, 1'b1, 3'd3, 1'b1};
        vecs[15] = {1'b1, 1'b0, 3'd3, 1'b1};
        vecs[16] = {1'b1, 1'b0, 3'd4, 1'b1};
        vecs[17] = {1'b1, 1'b0, 3'd4, 1'b1};
        vecs[18] = {1'b1, 1'b0, 3'd5, 1'b1};
        vecs[19] = {1'b1, 1'b0, 3'd0, 1'b1};
        vecs[20] = {1'b1, 1'b0, 3'd0, 1'b1};
        vecs[21] = {1'b1, 1'b0, 3'd0, 1'b1};
        vecs[22] = {1'b1, 1'b0, 3'd0, 1'b1};
        vecs[23] = {1'b1, 1'b0, 3'd1, 1'b1};

        seq6 = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3,
                 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0};

        // async reset with no clock edge in between
        #2 reset = 1'b0;
        #1;
        check3("rst0/state", state_o, 3'd0);
        check3("rst0/ns", ns_light, 3'b001);
        check3("rst0/ew", ew_light, 3'b100);
        check3("rst0/req", {2'b00, ew_req_o}, 3'b000);
        @(negedge clk);
        reset = 1'b1;

        do_reset();
        for (int i = 0; i < 24; i++)
            step(vecs[i].t, vecs[i].s, vecs[i].st, vecs[i].req, $sformatf("vec%0d", i));

        // no request: rest in NS green
        do_reset();
        for (int c = 0; c < 200; c++)
            step((c % 8) == 7, 1'b0, 3'd0, 1'b0, "idle");

        // single sensor pulse: full 14-tick cycle, then rest again
        do_reset();
        ticks = 0;
        for (int c = 0; c < 120; c++) begin
            t = ((c % 8) == 7);
            if (t) ticks++;
            step(t, c == 2, state_after_ticks(ticks), (c >= 2) && (ticks < 7),
                 $sformatf("pulse_c%0d", c));
        end

        // request arriving after a long main green is served on the next tick
        do_reset();
        for (int c = 0; c < 96; c++)
            step((c % 8) == 7, c >= 80, (c >= 87) ? 3'd1 : 3'd0, c >= 80,
                 $sformatf("late_c%0d", c));

        // reset during EW green with a fresh request pending
        do_reset();
        ticks = 0;
        for (int c = 0; c < 57; c++) begin
            t = ((c % 8) == 7);
            if (t) ticks++;
            step(t, (c == 2) || (c == 56), state_after_ticks(ticks),
                 ((c >= 2) && (ticks < 7)) || (c == 56), $sformatf("ewrst_c%0d", c));
        end
        #2 reset = 1'b0;
        #1;
        check3("ewrst/state", state_o, 3'd0);
        check3("ewrst/ns", ns_light, 3'b001);
        check3("ewrst/ew", ew_light, 3'b100);
        check3("ewrst/req", {2'b00, ew_req_o}, 3'b000);
        tick = 1'b0;
        sensor_ew = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // tick and sensor held high: 14-cycle period
        do_reset();
        for (int k = 0; k < 42; k++)
            step(1'b1, 1'b1, seq6[k % 14], (k % 14) != 6, $sformatf("held_k%0d", k));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
